// File: rtl/iomem_periph_resp.sv
// Responder for the picosoc iomem bus: 256-byte window holding GPIO registers
// and a 32-bit compare timer whose interrupt is presented as a registered level.
module iomem_periph_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          WAIT_STATES = 1,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  localparam logic [5:0] IDX_GPIO_OUT = 6'h00;
  localparam logic [5:0] IDX_GPIO_IN  = 6'h01;
  localparam logic [5:0] IDX_CTRL     = 6'h02;
  localparam logic [5:0] IDX_CMP      = 6'h03;
  localparam logic [5:0] IDX_CNT      = 6'h04;
  localparam logic [5:0] IDX_STATUS   = 6'h05;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [GPIO_W-1:0]   gpio_q, gpio_d;
  logic [GPIO_W-1:0]   sync1_q, sync2_q;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         cmp_q, cmp_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                irq_q, irq_d;

  logic                hit;
  logic                ack;
  logic                wr_en;
  logic [5:0]          idx;
  logic [31:0]         rd_val;
  logic [31:0]         gpio_w32;
  logic [31:0]         ctrl_w32;
  logic                match;
  logic                unused_ok;

  assign hit   = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign ack   = (state_q == S_ACK);
  assign wr_en = ack && (iomem_wstrb != 4'b0000);
  assign idx   = iomem_addr[7:2];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          wcnt_d  = WS;
          state_d = (WS != 3'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!iomem_valid) begin
          state_d = S_IDLE;
        end else if (wcnt_q <= 3'd1) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = 3'(wcnt_q - 3'd1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = 32'h0;
    case (idx)
      IDX_GPIO_OUT: rd_val = 32'(gpio_q);
      IDX_GPIO_IN:  rd_val = 32'(sync2_q);
      IDX_CTRL:     rd_val = 32'(ctrl_q);
      IDX_CMP:      rd_val = cmp_q;
      IDX_CNT:      rd_val = cnt_q;
      IDX_STATUS:   rd_val = 32'(pend_q);
      default:      rd_val = 32'h0;
    endcase
  end

  assign iomem_ready = ack;
  assign iomem_rdata = ack ? rd_val : 32'h0;

  // Register writes merge byte lanes; timer update is overridden by a CNT write
  // and a compare match overrides a simultaneous status clear.
  always_comb begin
    gpio_w32 = merge_bytes(32'(gpio_q), iomem_wdata, iomem_wstrb);
    ctrl_w32 = merge_bytes(32'(ctrl_q), iomem_wdata, iomem_wstrb);
    gpio_d   = gpio_q;
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    match    = ctrl_q[0] && (cnt_q == cmp_q);

    if (ctrl_q[0]) begin
      cnt_d = (match && ctrl_q[1]) ? 32'h0 : cnt_q + 32'd1;
    end

    if (wr_en) begin
      case (idx)
        IDX_GPIO_OUT: gpio_d = gpio_w32[GPIO_W-1:0];
        IDX_CTRL:     ctrl_d = ctrl_w32[2:0];
        IDX_CMP:      cmp_d  = merge_bytes(cmp_q, iomem_wdata, iomem_wstrb);
        IDX_CNT:      cnt_d  = merge_bytes(cnt_q, iomem_wdata, iomem_wstrb);
        IDX_STATUS:   if (iomem_wstrb[0] && iomem_wdata[0]) pend_d = 1'b0;
        default:      ;
      endcase
    end

    if (match) pend_d = 1'b1;
    irq_d = pend_q && ctrl_q[2];
  end

  assign unused_ok = ^{iomem_addr[1:0], gpio_w32, ctrl_w32};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      ctrl_q  <= 3'd0;
      cmp_q   <= 32'h0;
      cnt_q   <= 32'h0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio_out = gpio_q;
  assign irq_out  = irq_q;

endmodule

// File: tb/tb_iomem_periph_resp.sv
// Bench for iomem_periph_resp: one instance with 1 wait state, one with 3,
// checked cycle by cycle against a register-level reference model.
module tb_iomem_periph_resp;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        vld   [2];
  logic [3:0]  stb   [2];
  logic [31:0] adr   [2];
  logic [31:0] wd    [2];
  logic        rdy   [2];
  logic [31:0] rd    [2];
  logic [7:0]  gout  [2];
  logic        irq   [2];
  logic [7:0]  gin;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_gpio [2];
  logic [2:0]  m_ctrl [2];
  logic [31:0] m_cmp  [2];
  logic [31:0] m_cnt  [2];
  logic        m_pend [2];
  logic        m_irq  [2];
  logic [7:0]  m_gin;

  iomem_periph_resp #(.BASE_ADDR(BASE), .WAIT_STATES(1), .GPIO_W(8)) u_dut0 (
    .clk(clk), .resetn(rst_n[0]), .iomem_valid(vld[0]), .iomem_ready(rdy[0]),
    .iomem_wstrb(stb[0]), .iomem_addr(adr[0]), .iomem_wdata(wd[0]),
    .iomem_rdata(rd[0]), .gpio_in(gin), .gpio_out(gout[0]), .irq_out(irq[0])
  );

  iomem_periph_resp #(.BASE_ADDR(BASE), .WAIT_STATES(3), .GPIO_W(8)) u_dut1 (
    .clk(clk), .resetn(rst_n[1]), .iomem_valid(vld[1]), .iomem_ready(rdy[1]),
    .iomem_wstrb(stb[1]), .iomem_addr(adr[1]), .iomem_wdata(wd[1]),
    .iomem_rdata(rd[1]), .gpio_in(gin), .gpio_out(gout[1]), .irq_out(irq[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] n,
                                     input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset(input int k);
    m_gpio[k] = 8'h0; m_ctrl[k] = 3'h0; m_cmp[k] = 32'h0;
    m_cnt[k]  = 32'h0; m_pend[k] = 1'b0; m_irq[k] = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input int k, input logic [31:0] a);
    case (a[7:2])
      6'd0:    return {24'h0, m_gpio[k]};
      6'd1:    return {24'h0, m_gin};
      6'd2:    return {29'h0, m_ctrl[k]};
      6'd3:    return m_cmp[k];
      6'd4:    return m_cnt[k];
      6'd5:    return {31'h0, m_pend[k]};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: advance both models, optionally committing a write on model s.
  task automatic step(input int s, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    for (int k = 0; k < 2; k++) begin
      bit          en, match;
      logic [31:0] n_cnt, t;
      logic        n_pend, n_irq;
      en     = m_ctrl[k][0];
      match  = en && (m_cnt[k] == m_cmp[k]);
      n_irq  = m_pend[k] && m_ctrl[k][2];
      n_cnt  = m_cnt[k];
      if (en) n_cnt = (match && m_ctrl[k][1]) ? 32'h0 : m_cnt[k] + 32'd1;
      n_pend = m_pend[k];
      if (wr && k == s) begin
        case (a[7:2])
          6'd0: begin t = bm({24'h0, m_gpio[k]}, d, b); m_gpio[k] = t[7:0]; end
          6'd2: begin t = bm({29'h0, m_ctrl[k]}, d, b); m_ctrl[k] = t[2:0]; end
          6'd3: m_cmp[k] = bm(m_cmp[k], d, b);
          6'd4: n_cnt = bm(m_cnt[k], d, b);
          6'd5: if (b[0] && d[0]) n_pend = 1'b0;
          default: ;
        endcase
      end
      if (match) n_pend = 1'b1;
      m_cnt[k]  = n_cnt;
      m_pend[k] = n_pend;
      m_irq[k]  = n_irq;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gpio_out%0d", k), {24'h0, gout[k]}, {24'h0, m_gpio[k]});
      chk($sformatf("irq_out%0d", k), {31'h0, irq[k]}, {31'h0, m_irq[k]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Full transaction on instance s: fixed latency, one-cycle ready, read data check.
  task automatic bus(input int s, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    int ws;
    ws = (s == 0) ? 1 : 3;
    vld[s] = 1'b1; adr[s] = a; wd[s] = d; stb[s] = b;
    for (int i = 0; i <= ws; i++) begin
      chk($sformatf("ready_early%0d", s), {31'h0, rdy[s]}, 32'h0);
      chk($sformatf("rdata_idle%0d", s), rd[s], 32'h0);
      step(s, 1'b0, a, d, b);
    end
    chk($sformatf("ready_ack%0d", s), {31'h0, rdy[s]}, 32'h1);
    if (b == 4'h0) chk($sformatf("rdata%0d@%h", s, a[7:0]), rd[s], exp_read(s, a));
    step(s, b != 4'h0, a, d, b);
    vld[s] = 1'b0; stb[s] = 4'h0;
    chk($sformatf("ready_single%0d", s), {31'h0, rdy[s]}, 32'h0);
  endtask

  task automatic set_gin(input logic [7:0] v);
    gin = v;
    idle(3);
    m_gin = v;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; vld[k] = 1'b0; stb[k] = 4'h0; adr[k] = 32'h0; wd[k] = 32'h0;
      model_reset(k);
    end
    gin = 8'h0; m_gin = 8'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {31'h0, rdy[k]}, 32'h0);
      chk("rst_rdata", rd[k], 32'h0);
      chk("rst_gpio", {24'h0, gout[k]}, 32'h0);
      chk("rst_irq", {31'h0, irq[k]}, 32'h0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    idle(2);

    // GPIO out write/readback with byte strobe
    bus(0, BASE, 32'h0000_00A5, 4'b0001);
    bus(0, BASE, 32'h0, 4'h0);
    bus(0, BASE + 32'h1, 32'hFFFF_FF5A, 4'b0010);
    bus(0, BASE + 32'h3, 32'h0, 4'h0);

    // GPIO in through the synchroniser; writes to it ignored
    set_gin(8'h3C);
    bus(0, BASE + 32'h4, 32'h0, 4'h0);
    bus(0, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    bus(0, BASE + 32'h4, 32'h0, 4'h0);

    // Auto-reload compare timer with interrupt, then W1C
    bus(0, BASE + 32'hC, 32'd5, 4'hF);
    bus(0, BASE + 32'h8, 32'h7, 4'hF);
    idle(20);
    bus(0, BASE + 32'h14, 32'h0, 4'h0);
    bus(0, BASE + 32'h14, 32'h1, 4'hF);
    idle(4);
    bus(0, BASE + 32'h8, 32'h0, 4'hF);
    bus(0, BASE + 32'h14, 32'h1, 4'hF);
    bus(0, BASE + 32'h8, 32'h0, 4'h0);
    idle(3);

    // Free-running wrap from 0xFFFF_FFFF up to the compare value
    bus(0, BASE + 32'hC, 32'h10, 4'hF);
    bus(0, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    bus(0, BASE + 32'h8, 32'h1, 4'hF);
    bus(0, BASE + 32'h10, 32'h0, 4'h0);
    idle(25);
    bus(0, BASE + 32'h14, 32'h0, 4'h0);
    bus(0, BASE + 32'h10, 32'h0000_0100, 4'hF);
    bus(0, BASE + 32'h10, 32'h0, 4'h0);
    bus(0, BASE + 32'h8, 32'h0, 4'hF);
    bus(0, BASE + 32'h14, 32'h1, 4'hF);

    // Foreign window: never acknowledged, no state change
    vld[0] = 1'b1; adr[0] = 32'h0400_0000; wd[0] = 32'h0000_005A; stb[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      chk("miss_ready", {31'h0, rdy[0]}, 32'h0);
      step(0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    vld[0] = 1'b0; stb[0] = 4'h0;
    bus(0, BASE, 32'h0, 4'h0);

    // Unmapped offset inside the window
    bus(0, BASE + 32'h40, 32'hDEAD_BEEF, 4'hF);
    bus(0, BASE + 32'h40, 32'h0, 4'h0);
    bus(0, BASE, 32'h0, 4'h0);

    // Three-wait-state instance: normal write, valid drop in WAIT, reset in WAIT
    bus(1, BASE, 32'h11, 4'hF);
    bus(1, BASE, 32'h0, 4'h0);
    vld[1] = 1'b1; adr[1] = BASE; wd[1] = 32'h99; stb[1] = 4'hF;
    step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    vld[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drop_ready", {31'h0, rdy[1]}, 32'h0);
      step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    stb[1] = 4'h0;
    bus(1, BASE, 32'h0, 4'h0);
    vld[1] = 1'b1; adr[1] = BASE; wd[1] = 32'h77; stb[1] = 4'hF;
    step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n[1] = 1'b0;
    model_reset(1);
    #1;
    chk("rstwait_ready", {31'h0, rdy[1]}, 32'h0);
    chk("rstwait_gpio", {24'h0, gout[1]}, 32'h0);
    vld[1] = 1'b0; stb[1] = 4'h0;
    idle(2);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rstwait_idle", {31'h0, rdy[1]}, 32'h0);
      step(1, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    bus(1, BASE, 32'h0, 4'h0);
    bus(1, BASE, 32'h42, 4'b0001);
    bus(1, BASE, 32'h0, 4'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 150; n++) begin
      int          r;
      logic [5:0]  ix;
      logic [31:0] a, d;
      logic [3:0]  b;
      r  = $urandom_range(0, 8);
      ix = (r == 8) ? 6'h10 : 6'(r);
      a  = BASE + {24'h0, ix, 2'b00} + 32'($urandom_range(0, 3));
      d  = (ix == 6'd3 || ix == 6'd4) ? 32'($urandom_range(0, 30)) : $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus(0, a, d, b);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) set_gin(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iomem_periph_resp.md
# iomem_periph_resp

Memory-mapped peripheral that acts as the responder on the picosoc `iomem_*` bus. It decodes a 256-byte address window and answers transactions with a fixed, parameterised wait-state count. Behind the window are a GPIO output/input pair and a 32-bit compare timer whose interrupt feeds one of the core's `irq_5/6/7` inputs. It sits on the core side of the pad ring, between the core's `iomem_*` nets and the `irq_*` inputs.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: window base; only `[31:8]` is compared.
- `WAIT_STATES`, default 1: extra cycles before `iomem_ready`; legal range 0..7.
- `GPIO_W`, default 8: GPIO width; legal range 1..32.
- `clk`  in  1  single clock; all state is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `iomem_valid`  in  1  request from the core; held high until the edge where `iomem_ready` is sampled high.
- `iomem_ready`  out  1  single-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid only while `iomem_ready`=1, otherwise 0.
- `gpio_in`  in  `GPIO_W`  asynchronous external inputs.
- `gpio_out`  out  `GPIO_W`  registered outputs.
- `irq_out`  out  1  level interrupt.

## Operation
- Hit: `iomem_valid` & (`iomem_addr[31:8]` == `BASE_ADDR[31:8]`).
- On a miss, the block never asserts `iomem_ready` and never changes state; another responder owns that address.
- Registers are selected by `addr[7:2]`; `addr[1:0]` is ignored.
  - 0x00 GPIO_OUT: RW; `[GPIO_W-1:0]`.
  - 0x04 GPIO_IN: RO; value after a 2-flop synchroniser; writes are ignored.
  - 0x08 CTRL: RW; bit0 timer enable, bit1 auto-reload, bit2 irq enable; other bits read 0.
  - 0x0C CMP: RW; 32-bit.
  - 0x10 CNT: RW; 32-bit.
  - 0x14 STATUS: bit0 pending; write-1-to-clear.
  - Other offsets: read 0, writes ignored, still acknowledged.
- Writes honour per-byte `wstrb` lanes on every RW register.
- Writes commit on the edge where `iomem_ready`=1, never earlier.
- FSM states are IDLE, WAIT and ACK.
  - IDLE → hit: load the wait counter with `WAIT_STATES`. Go to WAIT if it is nonzero, otherwise to ACK.
  - WAIT: decrement the counter; go to ACK when it reaches 1. If `iomem_valid` drops, go to IDLE with no write.
  - ACK: `iomem_ready`=1, rdata driven, write committed; next state is IDLE unconditionally.
- Timer, when enabled, behaves as follows each cycle:
  - CNT += 1, wrapping 0xFFFF_FFFF → 0.
  - When CNT == CMP: set pending.
  - If auto-reload is set, CNT loads 0 on that cycle instead of incrementing.
- Priorities:
  - A bus write to CNT beats the increment or reload on the same edge.
  - A pending set beats a simultaneous W1C clear.
- `irq_out` = pending & CTRL.bit2, registered.

## Timing
- Reset (async assert, sync release): FSM IDLE, `iomem_ready`=0, `iomem_rdata`=0, `gpio_out`=0, CTRL/CMP/CNT/STATUS=0, synchroniser flops 0, `irq_out`=0.
- Latency: `iomem_ready` goes high `WAIT_STATES`+1 cycles after the first cycle `iomem_valid` is sampled high with a hit. For `WAIT_STATES`=0 this is the next cycle.
- `iomem_ready` is high for exactly one cycle per transaction.
- Back-to-back: a new hit is accepted in the cycle after ACK (IDLE), giving a minimum period of `WAIT_STATES`+2 cycles.
- GPIO_IN reflects `gpio_in` 2 cycles late.
- Timer:
  - A CMP match on edge N sets pending at N.
  - `irq_out` rises at N+1.
  - A W1C committed at edge M drops `irq_out` at M+1 unless a match also occurs at M.
- Reset asserted mid-transaction aborts with no write and no `iomem_ready` pulse.

## Test plan
- Write 0xA5 to 0x0300_0000 with wstrb=4'b0001 and `WAIT_STATES`=1 → `iomem_ready` high 2 cycles after valid, for 1 cycle; `gpio_out`=0xA5; a read of 0x00 returns 0x0000_00A5.
- Set `gpio_in`=0x3C → a read of 0x04 issued 3 or more cycles later returns 0x3C; a write to 0x04 leaves it unchanged.
- Write CMP=5, then CTRL=0x7 → pending sets when CNT=5, CNT reloads to 0, and `irq_out` rises 1 cycle later. Write STATUS=1 → `irq_out` falls the next cycle.
- Write CNT=0xFFFF_FFFF with CTRL=0x1 and CMP=0x10 → CNT wraps to 0 and reaches 0x10, then pending sets. A CNT write landing on an increment edge wins.
- Access 0x0400_0000 → `iomem_ready` never asserts. Access 0x0300_0040 → read returns 0 and `iomem_ready` pulses.
- Drop `iomem_valid` during WAIT (`WAIT_STATES`=3), and separately assert `resetn`=0 mid-WAIT → no `iomem_ready`, no register change, FSM back in IDLE.
